// File: rtl/mcu_pio_pkg.sv
// mcu_pio_pkg
// Shared definitions for the MCU PIO/LED peripherals: Avalon-MM word
// addresses of the LED output register map, blink period width and the
// blink timer state encoding.
package mcu_pio_pkg;

    localparam int PERIOD_W = 24;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/mcu_led_blink_timer.sv
// mcu_led_blink_timer
// Blink phase generator: 24-bit down-counter that reloads from the period
// and toggles the phase every period+1 cycles. A period of zero halts the
// timer with phase held low.
// Only built when MCU_LED_OUT_BLINK_EN is defined.
//
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   period    - period value in effect from the next edge on (on a period
//               write this is already the newly written value)
//   period_wr - period register is being written this cycle
//   phase_o   - blink phase
//
// state    | meaning
// ---------+-----------------------------------------------
// TMR_IDLE | period is 0: counter held at 0, phase forced 0
// TMR_RUN  | counting down, phase toggles at terminal count
`ifdef MCU_LED_OUT_BLINK_EN
module mcu_led_blink_timer
    import mcu_pio_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 24'd12_499_999
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase_o
);

    localparam tmr_state_e STATE_RESET = (PERIOD_RESET != '0) ? TMR_RUN : TMR_IDLE;

    tmr_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_RESET;
            cnt_q   <= PERIOD_RESET;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr) begin
            // a period write restarts the count and wins over reload/decrement
            cnt_d   = period;
            phase_d = 1'b0;
            state_d = (period == '0) ? TMR_IDLE : TMR_RUN;
        end else begin
            case (state_q)
                TMR_IDLE: begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                TMR_RUN: begin
                    if (cnt_q == '0) begin
                        cnt_d   = period;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q - PERIOD_W'(1);
                    end
                end
                default: begin
                    state_d = TMR_IDLE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    assign phase_o = phase_q;

endmodule
`endif

// File: rtl/mcu_led_out.sv
// mcu_led_out
// Avalon-MM LED output port with set/clear strobes and optional blinking.
// Build option: define MCU_LED_OUT_BLINK_EN to include the blink mask,
// period register and blink timer; without it addresses 1 and 2 read 0,
// ignore writes, and out_port simply follows data.
//
// Ports:
//   clk, reset_n   - clock (rising edge) and async active-low reset
//   address        - word address (0 data, 1 mask, 2 period, 3 status,
//                    4 outset, 5 outclear)
//   chipselect     - slave select
//   write_n        - write strobe, active-low
//   writedata      - write data
//   readdata       - registered read data, 1-cycle latency, always updated
//   out_port       - registered LED drive
module mcu_led_out
    import mcu_pio_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 24'd12_499_999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = wdata_w;
                ADDR_OUTSET: data_d = data_q | wdata_w;
                ADDR_OUTCLR: data_d = data_q & ~wdata_w;
                default:     data_d = data_q;
            endcase
        end
    end

`ifdef MCU_LED_OUT_BLINK_EN
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr_en && (address == ADDR_PERIOD);
    assign period_d  = period_wr ? writedata[PERIOD_W-1:0] : period_q;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = wdata_w;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= PERIOD_RESET;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    // timer sees the post-write period so a write reloads the new value
    mcu_led_blink_timer #(
        .PERIOD_RESET (PERIOD_RESET)
    ) u_blink_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period_d),
        .period_wr (period_wr),
        .phase_o   (phase)
    );

    assign out_d = data_q ^ (mask_q & {WIDTH{phase}});
`else
    assign out_d = data_q;
`endif

    // read mux uses current register values, so a write shows up next cycle
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:   rdata_d[WIDTH-1:0] = data_q;
            ADDR_STATUS: rdata_d[WIDTH-1:0] = out_q;
`ifdef MCU_LED_OUT_BLINK_EN
            ADDR_MASK:   rdata_d[WIDTH-1:0] = mask_q;
            ADDR_PERIOD: rdata_d[PERIOD_W-1:0] = period_q;
`endif
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            out_q   <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_mcu_led_out.sv
module tb_mcu_led_out;

    localparam int WIDTH = 8;
`ifdef MCU_LED_OUT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [31:0] PERIOD_RST32 = 32'h00BE_BC1F;  // 12_499_999

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    mcu_led_out #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (8'h00),
        .PERIOD_RESET (24'd12_499_999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    typedef struct {
        logic [2:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  out;
        int          idx;
    } exp_t;

    vec_t vecs[19];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
    endtask

    initial begin
        exp_t e;
        // expectations after the edge that samples the row: readdata shows the
        // pre-write register, out_port shows data as it was before that edge
        vecs[0]  = '{3'd0, 1'b1, 1'b0, 32'h0000_00A5, 32'h0, 8'h00};
        vecs[1]  = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_00A5, 8'hA5};
        vecs[2]  = '{3'd4, 1'b1, 1'b0, 32'h0000_000F, 32'h0, 8'hA5};
        vecs[3]  = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_00AF, 8'hAF};
        vecs[4]  = '{3'd5, 1'b1, 1'b0, 32'h0000_0081, 32'h0, 8'hAF};
        vecs[5]  = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_002E, 8'h2E};
        vecs[6]  = '{3'd3, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_002E, 8'h2E};
        vecs[7]  = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_002E, 8'h2E};
        vecs[8]  = '{3'd1, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 8'h2E};
        vecs[9]  = '{3'd1, 1'b1, 1'b1, 32'h0, BLINK ? 32'h0000_0055 : 32'h0, 8'h2E};
        vecs[10] = '{3'd2, 1'b1, 1'b0, 32'h0, BLINK ? PERIOD_RST32 : 32'h0, 8'h2E};
        vecs[11] = '{3'd2, 1'b1, 1'b1, 32'h0, 32'h0, 8'h2E};
        vecs[12] = '{3'd6, 1'b1, 1'b0, 32'h0000_00FF, 32'h0, 8'h2E};
        vecs[13] = '{3'd7, 1'b1, 1'b0, 32'h0000_00FF, 32'h0, 8'h2E};
        vecs[14] = '{3'd0, 1'b0, 1'b0, 32'h0000_003C, 32'h0000_002E, 8'h2E};
        vecs[15] = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_002E, 8'h2E};
        vecs[16] = '{3'd3, 1'b1, 1'b1, 32'h0, 32'h0000_002E, 8'h2E};
        vecs[17] = '{3'd0, 1'b1, 1'b0, 32'h1234_5601, 32'h0000_002E, 8'h2E};
        vecs[18] = '{3'd0, 1'b1, 1'b1, 32'h0, 32'h0000_0001, 8'h01};

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_out_port", {24'h0, out_port}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            bus(vecs[i].addr, vecs[i].cs, vecs[i].wr_n, vecs[i].wd);
            sb.push_back('{vecs[i].exp_rd, vecs[i].exp_out, i});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_readdata", e.idx), readdata, e.rd);
            check($sformatf("vec%0d_out_port", e.idx), {24'h0, out_port}, {24'h0, e.out});
        end

`ifdef MCU_LED_OUT_BLINK_EN
        // blinking: data 0, mask 1, period 3 -> bit0 toggles every 4 cycles
        bus(3'd0, 1'b1, 1'b0, 32'h0);
        bus(3'd1, 1'b1, 1'b0, 32'h1);
        bus(3'd2, 1'b1, 1'b0, 32'h3);
        @(posedge clk);
        #1;
        bus(3'd3, 1'b1, 1'b1, 32'h0);
        begin
            logic [7:0] prev_out;
            logic [7:0] exp_out;
            prev_out = 8'h00;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk);
                #1;
                exp_out = ((((k - 1) / 4) % 2) == 1) ? 8'h01 : 8'h00;
                check($sformatf("blink_out_k%0d", k), {24'h0, out_port}, {24'h0, exp_out});
                check($sformatf("blink_status_k%0d", k), readdata, {24'h0, prev_out});
                prev_out = exp_out;
            end
        end
        // halt mid-count (phase is 1 here)
        bus(3'd2, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        bus(3'd3, 1'b1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("halt_out_port", {24'h0, out_port}, 32'h0);
        // restart with period 2: phase rises 3 edges later, out one edge after
        bus(3'd2, 1'b1, 1'b0, 32'h2);
        @(posedge clk);
        bus(3'd3, 1'b1, 1'b1, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("restart_out_before", {24'h0, out_port}, 32'h0);
        @(posedge clk);
        #1;
        check("restart_out_toggle", {24'h0, out_port}, 32'h1);
`endif

        // asynchronous reset in the middle of a cycle
        bus(3'd0, 1'b1, 1'b0, 32'h0000_00F0);
        bus(3'd0, 1'b1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("pre_reset_readdata", readdata, 32'h0000_00F0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_out_port", {24'h0, out_port}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus(3'd2, 1'b1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("post_reset_period", readdata, BLINK ? PERIOD_RST32 : 32'h0);
        bus(3'd1, 1'b1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("post_reset_mask", readdata, 32'h0);
        bus(3'd0, 1'b1, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("post_reset_data", readdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
